// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: opcode bit positions, FSM states,
// decoded-operation struct and bus lane helpers.
package load_store_unit_pkg;

   localparam int LSI_LB  = 7;
   localparam int LSI_LH  = 6;
   localparam int LSI_LW  = 5;
   localparam int LSI_LBU = 4;
   localparam int LSI_LHU = 3;
   localparam int LSI_SB  = 2;
   localparam int LSI_SH  = 1;
   localparam int LSI_SW  = 0;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_e;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

   typedef struct packed {
      logic  store;
      logic  sgn;
      size_e size;
   } op_t;

   function automatic int lane_w(input int bus_w);
      return $clog2(bus_w / 8);
   endfunction

   // Highest set bit of the one-hot select wins.
   function automatic op_t decode_op(input logic [7:0] lsi);
      op_t op;
      op.store = 1'b0;
      op.sgn   = 1'b0;
      op.size  = SZ_B;
      if (lsi[LSI_LB]) begin
         op.sgn = 1'b1;
      end else if (lsi[LSI_LH]) begin
         op.sgn  = 1'b1;
         op.size = SZ_H;
      end else if (lsi[LSI_LW]) begin
         op.size = SZ_W;
      end else if (lsi[LSI_LBU]) begin
         op.size = SZ_B;
      end else if (lsi[LSI_LHU]) begin
         op.size = SZ_H;
      end else if (lsi[LSI_SB]) begin
         op.store = 1'b1;
      end else if (lsi[LSI_SH]) begin
         op.store = 1'b1;
         op.size  = SZ_H;
      end else if (lsi[LSI_SW]) begin
         op.store = 1'b1;
         op.size  = SZ_W;
      end
      return op;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Memory-bus handshake between the load/store unit (master) and memory (slave).
interface load_store_unit_if #(
   parameter int BUS_W  = 32,
   parameter int ADDR_W = 32
);
   logic              bus_req_o;
   logic              bus_we_o;
   logic [ADDR_W-1:0] bus_addr_o;
   logic [BUS_W/8-1:0] bus_be_o;
   logic [BUS_W-1:0]  bus_wdata_o;
   logic              bus_gnt_i;
   logic              bus_rvalid_i;
   logic              bus_err_i;
   logic [BUS_W-1:0]  bus_rdata_i;

   modport master (
      output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
      input  bus_gnt_i, bus_rvalid_i, bus_err_i, bus_rdata_i
   );

   modport slave (
      input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
      output bus_gnt_i, bus_rvalid_i, bus_err_i, bus_rdata_i
   );
endinterface

// File: rtl/load_store_unit_align.sv
// Byte-lane steering: store byte enables and data shift, load lane extraction
// with sign/zero extension. Purely combinational.
module lsu_align
   import load_store_unit_pkg::*;
#(
   parameter int BUS_W = 32
) (
   input  op_t                       op_i,
   input  logic [lane_w(BUS_W)-1:0]  lane_i,
   input  logic [31:0]               wdata_i,
   input  logic [BUS_W-1:0]          rdata_i,
   output logic [BUS_W/8-1:0]        be_o,
   output logic [BUS_W-1:0]          wdata_o,
   output logic [31:0]               rdata_o
);
   localparam int NB = BUS_W / 8;
   localparam int LW = lane_w(BUS_W);

   logic [NB-1:0]    be_base;
   logic [BUS_W-1:0] wd_mask;
   logic [31:0]      rd_sh;
   logic [LW+2:0]    sh;

   always_comb begin
      sh      = {lane_i, 3'b000};
      be_base = '0;
      wd_mask = '0;
      case (op_i.size)
         SZ_B: begin
            be_base[0]    = 1'b1;
            wd_mask[7:0]  = wdata_i[7:0];
         end
         SZ_H: begin
            be_base[1:0]  = 2'b11;
            wd_mask[15:0] = wdata_i[15:0];
         end
         default: begin
            be_base[3:0]  = 4'hF;
            wd_mask[31:0] = wdata_i;
         end
      endcase
      be_o    = be_base << lane_i;
      wdata_o = wd_mask << sh;
      rd_sh   = 32'(rdata_i >> sh);
      case (op_i.size)
         SZ_B:    rdata_o = {{24{op_i.sgn & rd_sh[7]}}, rd_sh[7:0]};
         SZ_H:    rdata_o = {{16{op_i.sgn & rd_sh[15]}}, rd_sh[15:0]};
         default: rdata_o = rd_sh;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: accepts one operation at a time, runs the bus
// handshake with grant/response timeouts and pulses done_o for one cycle.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int BUS_W   = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   input  logic [7:0]        load_store_info_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [31:0]       mem_write_data_i,
   output logic [31:0]       mem_read_data_o,
   output logic              stall_o,
   output logic              done_o,
   output logic              misalign_o,
   output logic              bus_err_o,
   load_store_unit_if.master bus
);
   localparam int         LW       = lane_w(BUS_W);
   localparam int         NB       = BUS_W / 8;
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_e            state_q;
   op_t               op_q, op_d;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q, rdata_q, rd_ext;
   logic [7:0]        cnt_q;
   logic              req_q, we_q, done_q, misal_q, err_q;
   logic              mem_op, misal_d;
   logic [NB-1:0]     be;
   logic [BUS_W-1:0]  wd_lane;

   assign mem_op  = valid_i && (load_store_info_i != 8'd0);
   assign op_d    = decode_op(load_store_info_i);
   assign misal_d = (op_d.size == SZ_H && mem_addr_i[0]) ||
                    (op_d.size == SZ_W && mem_addr_i[1:0] != 2'b00);

   lsu_align #(.BUS_W(BUS_W)) u_align (
      .op_i    (op_q),
      .lane_i  (addr_q[LW-1:0]),
      .wdata_i (wdata_q),
      .rdata_i (bus.bus_rdata_i),
      .be_o    (be),
      .wdata_o (wd_lane),
      .rdata_o (rd_ext)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
         misal_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         // Completion flags and load data live for the DONE cycle only.
         done_q  <= 1'b0;
         misal_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         case (state_q)
            S_IDLE: if (mem_op) begin
               op_q    <= op_d;
               addr_q  <= mem_addr_i;
               wdata_q <= mem_write_data_i;
               cnt_q   <= '0;
               if (misal_d) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  misal_q <= 1'b1;
               end else begin
                  state_q <= S_REQ;
                  req_q   <= 1'b1;
                  we_q    <= op_d.store;
               end
            end
            S_REQ: begin
               if (bus.bus_gnt_i) begin
                  req_q <= 1'b0;
                  we_q  <= 1'b0;
                  cnt_q <= '0;
                  if (bus.bus_err_i || op_q.store) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     err_q   <= bus.bus_err_i;
                  end else begin
                     state_q <= S_RESP;
                  end
               end else if (cnt_q == TMO_LAST) begin
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_RESP: begin
               if (bus.bus_rvalid_i) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  err_q   <= bus.bus_err_i;
                  rdata_q <= bus.bus_err_i ? 32'd0 : rd_ext;
               end else if (cnt_q == TMO_LAST) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Gated by rst so a pending operation cannot hold the pipe during reset.
   assign stall_o = !rst && ((state_q == S_IDLE && mem_op) ||
                             state_q == S_REQ || state_q == S_RESP);

   assign done_o          = done_q;
   assign misalign_o      = misal_q;
   assign bus_err_o       = err_q;
   assign mem_read_data_o = rdata_q;

   assign bus.bus_req_o   = req_q;
   assign bus.bus_we_o    = we_q;
   assign bus.bus_addr_o  = req_q ? {addr_q[ADDR_W-1:LW], {LW{1'b0}}} : '0;
   assign bus.bus_be_o    = req_q ? be : '0;
   assign bus.bus_wdata_o = (req_q && we_q) ? wd_lane : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: 32-bit bus with short timeout plus a
// 64-bit instance for lane-steering checks.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid = 1'b0, valid64 = 1'b0;
   logic [7:0]  info = '0, info64 = '0;
   logic [31:0] addr = '0, addr64 = '0, wdata = '0, wdata64 = '0;
   logic [31:0] rdata, rdata64;
   logic        stall, done, mis, err, stall64, done64, mis64, err64;
   int          n_chk = 0, n_err = 0;

   always #5 clk = ~clk;

   load_store_unit_if #(.BUS_W(32), .ADDR_W(32)) bif ();
   load_store_unit_if #(.BUS_W(64), .ADDR_W(32)) bif64 ();

   load_store_unit #(.BUS_W(32), .ADDR_W(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .valid_i(valid), .load_store_info_i(info),
      .mem_addr_i(addr), .mem_write_data_i(wdata), .mem_read_data_o(rdata),
      .stall_o(stall), .done_o(done), .misalign_o(mis), .bus_err_o(err),
      .bus(bif)
   );

   load_store_unit #(.BUS_W(64), .ADDR_W(32)) dut64 (
      .clk(clk), .rst(rst), .valid_i(valid64), .load_store_info_i(info64),
      .mem_addr_i(addr64), .mem_write_data_i(wdata64), .mem_read_data_o(rdata64),
      .stall_o(stall64), .done_o(done64), .misalign_o(mis64), .bus_err_o(err64),
      .bus(bif64)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] rd, input logic [31:0] exp);
      step(); valid = 1'b1; info = op; addr = a; #1;
      chk({tag, "/stall0"}, stall, 1);
      step(); bif.bus_gnt_i = 1'b1; #1;
      chk({tag, "/req"}, bif.bus_req_o, 1);
      chk({tag, "/addr"}, bif.bus_addr_o, a & ~32'h3);
      step(); bif.bus_gnt_i = 1'b0; bif.bus_rvalid_i = 1'b1; bif.bus_rdata_i = rd; #1;
      chk({tag, "/req_off"}, bif.bus_req_o, 0);
      chk({tag, "/stall2"}, stall, 1);
      step(); bif.bus_rvalid_i = 1'b0; bif.bus_rdata_i = '0; valid = 1'b0; #1;
      chk({tag, "/done"}, done, 1);
      chk({tag, "/data"}, rdata, exp);
      chk({tag, "/stall_done"}, stall, 0);
      chk({tag, "/err"}, err, 0);
      step(); #1;
      chk({tag, "/done_off"}, done, 0);
      chk({tag, "/data_off"}, rdata, 0);
   endtask

   // waits = REQ cycles without grant before the granting cycle
   task automatic store_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] ebe, input logic [31:0] ewd,
                           input int waits, input logic berr);
      step(); valid = 1'b1; info = op; addr = a; wdata = d; #1;
      chk({tag, "/stall0"}, stall, 1);
      for (int i = 0; i <= waits; i++) begin
         step();
         bif.bus_gnt_i = (i == waits);
         bif.bus_err_i = berr && (i == waits);
         addr = ~a; wdata = ~d;
         #1;
         chk({tag, "/req"}, bif.bus_req_o, 1);
         chk({tag, "/we"}, bif.bus_we_o, 1);
         chk({tag, "/be"}, bif.bus_be_o, ebe);
         chk({tag, "/wdata"}, bif.bus_wdata_o, ewd);
         chk({tag, "/addr"}, bif.bus_addr_o, a & ~32'h3);
      end
      step(); bif.bus_gnt_i = 1'b0; bif.bus_err_i = 1'b0; valid = 1'b0; #1;
      chk({tag, "/done"}, done, 1);
      chk({tag, "/buserr"}, err, berr);
      chk({tag, "/stall_done"}, stall, 0);
      chk({tag, "/req_off"}, bif.bus_req_o, 0);
      step(); #1;
      chk({tag, "/done_off"}, done, 0);
   endtask

   task automatic misal_op(input string tag, input logic [7:0] op, input logic [31:0] a);
      step(); valid = 1'b1; info = op; addr = a; #1;
      chk({tag, "/stall0"}, stall, 1);
      step(); valid = 1'b0; #1;
      chk({tag, "/done"}, done, 1);
      chk({tag, "/mis"}, mis, 1);
      chk({tag, "/noreq"}, bif.bus_req_o, 0);
      chk({tag, "/stall"}, stall, 0);
      step(); #1;
      chk({tag, "/done_off"}, done, 0);
      chk({tag, "/mis_off"}, mis, 0);
   endtask

   initial begin
      bif.bus_gnt_i = 1'b0; bif.bus_rvalid_i = 1'b0; bif.bus_err_i = 1'b0; bif.bus_rdata_i = '0;
      bif64.bus_gnt_i = 1'b0; bif64.bus_rvalid_i = 1'b0; bif64.bus_err_i = 1'b0; bif64.bus_rdata_i = '0;

      // reset state, with a pending lw that must not stall
      #2 rst = 1'b1; valid = 1'b1; info = 8'h20; #1;
      chk("rst/stall", stall, 0);
      chk("rst/req", bif.bus_req_o, 0);
      chk("rst/done", done, 0);
      chk("rst/rdata", rdata, 0);
      chk("rst/be", bif.bus_be_o, 0);
      step(); step(); valid = 1'b0; info = '0; rst = 1'b0;

      // non-memory instructions
      step(); valid = 1'b1; info = 8'h00; #1;
      chk("nomem/stall", stall, 0);
      step(); valid = 1'b0; info = 8'h20; #1;
      chk("novalid/stall", stall, 0);
      step(); #1;
      chk("nomem/req", bif.bus_req_o, 0);
      info = '0;

      load_op("lw",    8'h20, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
      load_op("lb",    8'h80, 32'h103, 32'h80FFFFFF, 32'hFFFFFF80);
      load_op("lbu",   8'h10, 32'h103, 32'h80FFFFFF, 32'h00000080);
      load_op("lh",    8'h40, 32'h102, 32'h80011234, 32'hFFFF8001);
      load_op("lhu",   8'h08, 32'h100, 32'h1234ABCD, 32'h0000ABCD);
      load_op("prio_lb", 8'hA0, 32'h101, 32'h00008500, 32'hFFFFFF85);

      store_op("sb", 8'h04, 32'h101, 32'hAABBCC55, 4'b0010, 32'h00005500, 0, 1'b0);
      store_op("sh", 8'h02, 32'h102, 32'hABCD1234, 4'b1100, 32'h12340000, 0, 1'b0);
      store_op("sw_wait", 8'h01, 32'h104, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 2, 1'b0);
      store_op("prio_sb", 8'h07, 32'h103, 32'h00000077, 4'b1000, 32'h77000000, 0, 1'b0);
      store_op("sw_err", 8'h01, 32'h108, 32'h00000001, 4'b1111, 32'h00000001, 0, 1'b1);

      misal_op("mis_lw", 8'h20, 32'h101);
      misal_op("mis_sh", 8'h02, 32'h103);

      // response timeout: 4 RESP cycles then error completion
      step(); valid = 1'b1; info = 8'h20; addr = 32'h200;
      step(); bif.bus_gnt_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(); bif.bus_gnt_i = 1'b0; #1;
         chk("tmo_resp/stall", stall, 1);
         chk("tmo_resp/done", done, 0);
      end
      step(); valid = 1'b0; #1;
      chk("tmo_resp/done", done, 1);
      chk("tmo_resp/err", err, 1);
      chk("tmo_resp/rdata", rdata, 0);
      chk("tmo_resp/req", bif.bus_req_o, 0);

      // grant timeout: 4 REQ cycles then error completion
      step(); valid = 1'b1; info = 8'h01; addr = 32'h600; wdata = 32'h5;
      for (int i = 0; i < 4; i++) begin
         step(); #1;
         chk("tmo_gnt/req", bif.bus_req_o, 1);
      end
      step(); valid = 1'b0; #1;
      chk("tmo_gnt/done", done, 1);
      chk("tmo_gnt/err", err, 1);
      chk("tmo_gnt/req", bif.bus_req_o, 0);

      // load error on rvalid returns zero data
      step(); valid = 1'b1; info = 8'h20; addr = 32'h500;
      step(); bif.bus_gnt_i = 1'b1;
      step(); bif.bus_gnt_i = 1'b0; bif.bus_rvalid_i = 1'b1; bif.bus_err_i = 1'b1; bif.bus_rdata_i = 32'hFFFFFFFF;
      step(); bif.bus_rvalid_i = 1'b0; bif.bus_err_i = 1'b0; valid = 1'b0; #1;
      chk("lerr/done", done, 1);
      chk("lerr/err", err, 1);
      chk("lerr/rdata", rdata, 0);

      // operation held through DONE is not accepted until the following IDLE
      step(); valid = 1'b1; info = 8'h01; addr = 32'h300; wdata = 32'h11223344;
      step(); bif.bus_gnt_i = 1'b1;
      step(); bif.bus_gnt_i = 1'b0; #1;
      chk("b2b/done1", done, 1);
      chk("b2b/stall_done", stall, 0);
      step(); #1;
      chk("b2b/no_accept", bif.bus_req_o, 0);
      chk("b2b/stall_idle", stall, 1);
      step(); bif.bus_gnt_i = 1'b1; #1;
      chk("b2b/req2", bif.bus_req_o, 1);
      step(); bif.bus_gnt_i = 1'b0; valid = 1'b0; #1;
      chk("b2b/done2", done, 1);

      // reset in RESP abandons the transfer; late rvalid ignored
      step(); valid = 1'b1; info = 8'h20; addr = 32'h400;
      step(); bif.bus_gnt_i = 1'b1;
      step(); bif.bus_gnt_i = 1'b0; #1;
      chk("rstmid/stall_resp", stall, 1);
      rst = 1'b1; #1;
      chk("rstmid/stall", stall, 0);
      chk("rstmid/req", bif.bus_req_o, 0);
      chk("rstmid/done", done, 0);
      step(); valid = 1'b0; bif.bus_rvalid_i = 1'b1; bif.bus_rdata_i = 32'h12345678; #1;
      chk("rstmid/done_rst", done, 0);
      step(); rst = 1'b0;
      step(); #1;
      chk("rstmid/late_done", done, 0);
      chk("rstmid/late_stall", stall, 0);
      step(); bif.bus_rvalid_i = 1'b0; #1;
      chk("rstmid/late_done2", done, 0);
      chk("rstmid/late_rdata", rdata, 0);

      // 64-bit bus: sh at 0x106
      step(); valid64 = 1'b1; info64 = 8'h02; addr64 = 32'h106; wdata64 = 32'h1234;
      step(); bif64.bus_gnt_i = 1'b1; #1;
      chk("b64_sh/be", bif64.bus_be_o, 64'hC0);
      chk("b64_sh/wdata", bif64.bus_wdata_o, 64'h1234_0000_0000_0000);
      chk("b64_sh/addr", bif64.bus_addr_o, 32'h100);
      step(); bif64.bus_gnt_i = 1'b0; valid64 = 1'b0; #1;
      chk("b64_sh/done", done64, 1);

      // 64-bit bus: lw at 0x104 reads the upper word
      step(); valid64 = 1'b1; info64 = 8'h20; addr64 = 32'h104;
      step(); bif64.bus_gnt_i = 1'b1; #1;
      chk("b64_lw/be", bif64.bus_be_o, 64'hF0);
      step(); bif64.bus_gnt_i = 1'b0; bif64.bus_rvalid_i = 1'b1; bif64.bus_rdata_i = 64'h89ABCDEF_00000000;
      step(); bif64.bus_rvalid_i = 1'b0; valid64 = 1'b0; #1;
      chk("b64_lw/done", done64, 1);
      chk("b64_lw/data", rdata64, 32'h89ABCDEF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The module SHALL have parameter BUS_W, default 32, giving the data-bus width; legal values are 32 and 64.
REQ-002 The module SHALL have parameter ADDR_W, default 32, giving the address width.
REQ-003 The module SHALL have parameter TIMEOUT, default 255, giving the maximum number of cycles to wait for grant or response; legal range is 1 to 255.
REQ-004 The module SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- valid_i  in  1  the instruction in the memory stage is valid.
- load_store_info_i  in  8  one-hot operation select: [7] lb, [6] lh, [5] lw, [4] lbu, [3] lhu, [2] sb, [1] sh, [0] sw.
- mem_addr_i  in  ADDR_W  byte address.
- mem_write_data_i  in  32  store data, right-aligned.
- mem_read_data_o  out  32  extended load result.
- stall_o  out  1  holds the pipeline.
- done_o  out  1  one-cycle completion pulse.
- misalign_o  out  1  misaligned-access exception, valid with done_o.
- bus_err_o  out  1  bus error or timeout, valid with done_o.
- bus_req_o, bus_we_o  out  1 each  bus request and write strobe.
- bus_addr_o  out  ADDR_W  bus address, aligned to BUS_W/8.
- bus_be_o  out  BUS_W/8  byte-lane enables.
- bus_wdata_o  out  BUS_W  lane-shifted write data.
- bus_gnt_i, bus_rvalid_i, bus_err_i  in  1 each  grant, read-data valid, error response.
- bus_rdata_i  in  BUS_W  read data.

Function
REQ-005 The module SHALL treat an operation as a memory operation when valid_i=1 and load_store_info_i is non-zero; if more than one bit is set, the highest set bit wins.
REQ-006 The module SHALL implement FSM states IDLE, REQ, RESP and DONE.
REQ-007 In IDLE, on a memory operation, the module SHALL register the opcode, address and data and SHALL go to REQ, or to DONE if the access is misaligned.
REQ-008 The module SHALL treat an access as misaligned when a halfword has addr[0]=1 or a word has addr[1:0]!=0.
REQ-009 A misaligned access SHALL issue no bus request and SHALL set misalign_o=1 in DONE.
REQ-010 In REQ, bus_req_o SHALL be 1, with bus_addr_o, bus_we_o, bus_be_o and bus_wdata_o stable until the edge at which bus_gnt_i=1.
REQ-011 At the edge where bus_gnt_i=1 in REQ, a store SHALL go to DONE and a load SHALL go to RESP.
REQ-012 In RESP, the module SHALL capture bus_rdata_i at the edge where bus_rvalid_i=1 and SHALL then go to DONE.
REQ-013 A load's byte lane SHALL be addr[log2(BUS_W/8)-1:0]; the selected lane SHALL be sign-extended (lb, lh) or zero-extended (lbu, lhu) to 32 bits.
REQ-014 For a store, bus_be_o SHALL be 1, 2 or 4 contiguous ones shifted to the lane, and bus_wdata_o SHALL be the data replicated or shifted onto that lane.
REQ-015 bus_err_i=1 sampled with gnt or rvalid SHALL take the FSM to DONE with bus_err_o=1; a load that errors SHALL return mem_read_data_o=0.
REQ-016 A per-state wait counter SHALL count cycles spent in REQ or RESP; reaching TIMEOUT SHALL take the FSM to DONE with bus_err_o=1 and bus_req_o=0.
REQ-017 DONE SHALL last exactly one cycle, with done_o=1 and mem_read_data_o held, and SHALL then return to IDLE.
REQ-018 A new operation SHALL NOT be accepted in the DONE cycle.
REQ-019 stall_o SHALL be 1 when a memory operation is present in IDLE, and throughout REQ and RESP; stall_o SHALL be 0 in DONE and for non-memory operations.
REQ-020 Minimum latency SHALL be: store with immediate grant = done at cycle 2 after accept; load with gnt at cycle 1 and rvalid at cycle 2 = done at cycle 3.
REQ-021 mem_read_data_o SHALL be 0 outside DONE.
REQ-022 For non-memory instructions, all bus outputs SHALL be 0 and there SHALL be no stall.

Reset
REQ-023 Asserting rst SHALL immediately force IDLE, clear the wait counter and registered operands, and drive all outputs to 0.
REQ-024 A reset mid-transaction SHALL abandon the bus request with no completion pulse.
REQ-025 Release of rst SHALL take effect at the next posedge clk.

Structure
REQ-026 A shared package SHALL hold the load_store_info bit-index constants, the FSM state enum and the lane-select width function.
REQ-027 A combinational sub-module lsu_align SHALL handle byte-enable generation, write-data shift and read extraction/extension.

Verification
REQ-028 lw at 0x100, gnt at cycle 1, rvalid at cycle 2 with rdata 0xDEADBEEF -> done_o at cycle 3 with mem_read_data_o=0xDEADBEEF and stall high on cycles 0-2.
REQ-029 lb at 0x103 with rdata 0x80FFFFFF and BUS_W=32 -> mem_read_data_o=0xFFFFFF80; lbu -> 0x00000080.
REQ-030 sh at 0x102 with data 0x1234 -> bus_be_o=4'b1100 and bus_wdata_o[31:16]=0x1234; with BUS_W=64 at 0x106 -> bus_be_o=8'hC0.
REQ-031 lw at 0x101 -> no bus_req_o, done_o=1 and misalign_o=1 at cycle 1.
REQ-032 With TIMEOUT=4, load granted but no rvalid -> bus_err_o=1 with done_o after 4 RESP cycles.
REQ-033 rst asserted while in RESP -> all outputs 0 immediately, and a late rvalid is ignored.
